stage6_operand_issuer: RTL

- Producer side of the pipe_stage6 operand interface. Buffers operand beats from the upstream tile datapath in a small FIFO.
- Under a job descriptor, issues them beat-by-beat as operandv/operand1..4.
- Marks set boundaries, tags each beat with its set index, latches mode, and pulses finished at job end.
- Sits between stage-5 output packing and pipe_stage6.

---
 rtl/stage6_operand_issuer_if.sv | 40 ++++
 rtl/stage6_operand_issuer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stage6_operand_issuer_if.sv
// Operand-issue bundle: upstream beat push, job control, and the pipe_stage6 operand outputs.
interface stage6_operand_issuer_if #(
  parameter int DW    = 16,
  parameter int SET_W = 8,
  parameter int LEN_W = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [5*DW-1:0]   in_data_i;
  logic              start_i;
  logic [SET_W-1:0]  num_sets_i;
  logic [LEN_W-1:0]  set_len_i;
  logic              mode_i;
  logic              abort_i;
  logic              stall_i;
  logic              out_valid_o;
  logic [DW-1:0]     operandv_o;
  logic [DW-1:0]     operand1_o;
  logic [DW-1:0]     operand2_o;
  logic [DW-1:0]     operand3_o;
  logic [DW-1:0]     operand4_o;
  logic              stage_boundary_o;
  logic [SET_W-1:0]  set_o;
  logic              mode_o;
  logic              finished_o;
  logic              busy_o;

  // Upstream/control side drives beats and job requests.
  modport master (
    output in_valid_i, in_data_i, start_i, num_sets_i, set_len_i, mode_i, abort_i, stall_i,
    input  in_ready_o, out_valid_o, operandv_o, operand1_o, operand2_o, operand3_o, operand4_o,
           stage_boundary_o, set_o, mode_o, finished_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_data_i, start_i, num_sets_i, set_len_i, mode_i, abort_i, stall_i,
    output in_ready_o, out_valid_o, operandv_o, operand1_o, operand2_o, operand3_o, operand4_o,
           stage_boundary_o, set_o, mode_o, finished_o, busy_o
  );
endinterface

// File: rtl/stage6_operand_issuer.sv
// Buffers operand beats in a small FIFO and issues them to pipe_stage6 under a
// job descriptor of num_sets x set_len beats, marking set boundaries and job end.
module stage6_operand_issuer #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int SET_W = 8,
  parameter int LEN_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  stage6_operand_issuer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [5*DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [SET_W-1:0] num_sets_q, num_sets_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [LEN_W-1:0] set_len_q, set_len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [5*DW-1:0]  operands_q, operands_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             boundary_q, boundary_d;
  logic             finished_q, finished_d;
  logic             busy_q, busy_d;

  logic             full, empty, push, issue, flush;
  logic             last_in_set, last_set;
  logic [5*DW-1:0]  head;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  // A full FIFO refuses the push even when the same cycle pops; no bypass path.
  assign push  = bus.in_valid_i && !full;
  assign issue = (state_q == RUN) && !empty && !bus.stall_i && !bus.abort_i;
  assign flush = (state_q == RUN) && bus.abort_i;
  assign head  = mem_q[rd_ptr_q];

  assign last_in_set = (beat_cnt_q == set_len_q - LEN_ONE);
  assign last_set    = (set_cnt_q == num_sets_q - SET_ONE);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : fifo_next
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, issue})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    num_sets_d  = num_sets_q;
    set_len_d   = set_len_q;
    mode_d      = mode_q;
    beat_cnt_d  = beat_cnt_q;
    set_cnt_d   = set_cnt_q;
    set_d       = set_q;
    operands_d  = operands_q;
    out_valid_d = 1'b0;
    boundary_d  = 1'b0;
    finished_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          num_sets_d = bus.num_sets_i;
          set_len_d  = bus.set_len_i;
          mode_d     = bus.mode_i;
          beat_cnt_d = '0;
          set_cnt_d  = '0;
          if (bus.num_sets_i == '0 || bus.set_len_i == '0) begin
            state_d    = DONE;
            finished_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (issue) begin
          operands_d  = head;
          out_valid_d = 1'b1;
          set_d       = set_cnt_q;
          boundary_d  = last_in_set;
          if (last_in_set) begin
            beat_cnt_d = '0;
            // The final beat holds set_cnt so it never passes the latched bound.
            if (last_set) begin
              state_d    = DONE;
              finished_d = 1'b1;
            end else begin
              set_cnt_d = set_cnt_q + SET_ONE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      num_sets_q  <= '0;
      set_len_q   <= '0;
      mode_q      <= 1'b0;
      beat_cnt_q  <= '0;
      set_cnt_q   <= '0;
      set_q       <= '0;
      operands_q  <= '0;
      out_valid_q <= 1'b0;
      boundary_q  <= 1'b0;
      finished_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      num_sets_q  <= num_sets_d;
      set_len_q   <= set_len_d;
      mode_q      <= mode_d;
      beat_cnt_q  <= beat_cnt_d;
      set_cnt_q   <= set_cnt_d;
      set_q       <= set_d;
      operands_q  <= operands_d;
      out_valid_q <= out_valid_d;
      boundary_q  <= boundary_d;
      finished_q  <= finished_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the beat storage has no reset; the reset count/pointers guarantee no entry is read before it is written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data_i;
  end

  assign bus.in_ready_o       = !full;
  assign bus.out_valid_o      = out_valid_q;
  assign bus.operandv_o       = operands_q[5*DW-1:4*DW];
  assign bus.operand1_o       = operands_q[4*DW-1:3*DW];
  assign bus.operand2_o       = operands_q[3*DW-1:2*DW];
  assign bus.operand3_o       = operands_q[2*DW-1:DW];
  assign bus.operand4_o       = operands_q[DW-1:0];
  assign bus.stage_boundary_o = boundary_q;
  assign bus.set_o            = set_q;
  assign bus.mode_o           = mode_q;
  assign bus.finished_o       = finished_q;
  assign bus.busy_o           = busy_q;
endmodule
